mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 98 +++++++++
 tb/tb_mul_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier that stalls the ALU pipeline while it runs.
// Optional early exit on an exhausted multiplier via MUL_SEQUENCER_EARLY_TERM_EN.
module mul_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iOperandA,
  input  logic [WIDTH-1:0] iOperandB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult,
  output logic             oStall
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_iter_c;
  logic               early_c;

  assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MUL_SEQUENCER_EARLY_TERM_EN
  // Remaining multiplier bits are all zero, so further steps add nothing.
  assign early_c = ((mplier_q >> 1) == '0);
`else
  assign early_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and shift-add datapath
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          mcand_d  = iOperandA;
          mplier_d = iOperandB;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter_c || early_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign oBusy   = (state_q == S_RUN);
  assign oDone   = (state_q == S_DONE);
  assign oResult = acc_q;
  // Freeze the pipeline in the very cycle a start is presented.
  assign oStall  = oBusy | ((state_q == S_IDLE) & iStart);

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: driver predicts accepted operations,
// a negedge monitor checks busy/done/stall/result every cycle.
module tb_mul_sequencer;

  localparam int unsigned W = 16;

  logic         Clock;
  logic         Reset;
  logic         iStart;
  logic [W-1:0] iOperandA;
  logic [W-1:0] iOperandB;
  logic         oBusy;
  logic         oDone;
  logic [W-1:0] oResult;
  logic         oStall;

  mul_sequencer #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iOperandA (iOperandA),
    .iOperandB (iOperandB),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oResult   (oResult),
    .oStall    (oStall)
  );

  typedef struct {
    logic [W-1:0] res;
    int           s;
    int           lat;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           next_free = 0;
  int           checks = 0;
  int           errors = 0;
  logic         armed = 1'b0;
  logic [W-1:0] held = '0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Number of RUN cycles the operation should take.
  function automatic int lat_of(input logic [W-1:0] b);
`ifdef MUL_SEQUENCER_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 0; i < int'(W); i++) if (b[i]) n = i + 1;
    return n;
`else
    return int'(W);
`endif
  endfunction

  function automatic logic [W-1:0] product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    return p[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs; record the expected product if it will be accepted.
  task automatic step(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic rst);
    exp_t e;
    @(posedge Clock);
    #1;
    Reset     = rst;
    iStart    = st;
    iOperandA = a;
    iOperandB = b;
    if (rst) begin
      next_free = cyc + 1;
    end else if (st && cyc >= next_free) begin
      e.res = product(a, b);
      e.s   = cyc;
      e.lat = lat_of(b);
      q.push_back(e);
      next_free = cyc + e.lat + 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom), 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor
  always @(negedge Clock) begin
    logic exp_busy, exp_done, exp_idle;
    exp_t h;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    if (armed) begin
      if (q.size() > 0) begin
        h = q[0];
        exp_busy = (cyc > h.s) && (cyc <= h.s + h.lat);
        exp_done = (cyc == h.s + h.lat + 1);
      end
      exp_idle = !(exp_busy || exp_done);
      chk("busy", 32'(oBusy), 32'(exp_busy));
      chk("done", 32'(oDone), 32'(exp_done));
      chk("stall", 32'(oStall), 32'(exp_busy | (exp_idle & iStart)));
      if (exp_done) begin
        chk("result", 32'(oResult), 32'(h.res));
        held = h.res;
        void'(q.pop_front());
      end else if (exp_idle) begin
        chk("result_hold", 32'(oResult), 32'(held));
      end
    end
    if (Reset) begin
      q.delete();
      held  = '0;
      armed = 1'b1;
    end
  end

  initial begin
    int wait_cnt;
    Reset = 1'b1;
    iStart = 1'b0;
    iOperandA = '0;
    iOperandB = '0;
    step(1'b1, W'(7), W'(7), 1'b1);
    step(1'b1, W'(1), W'(2), 1'b1);
    step(1'b0, '0, '0, 1'b0);

    step(1'b1, W'(3), W'(5), 1'b0);
    idle(20);
    step(1'b1, '1, '1, 1'b0);
    idle(19);
    step(1'b1, W'(16'h1234), '0, 1'b0);
    idle(19);
    step(1'b1, W'(7), W'(2), 1'b0);
    idle(19);
    step(1'b1, W'(5), W'(16'h8000), 1'b0);
    idle(19);

    // Late second request is ignored.
    step(1'b1, W'(2), W'(3), 1'b0);
    idle(4);
    step(1'b1, W'(9), W'(9), 1'b0);
    idle(16);

    // Abort mid-run, then a fresh product.
    step(1'b1, W'(16'h00FF), W'(16'h0101), 1'b0);
    idle(7);
    step(1'b0, '0, '0, 1'b1);
    idle(2);
    step(1'b1, W'(4), W'(4), 1'b0);
    idle(19);

    // Continuous start gives back-to-back operations.
    for (int i = 0; i < 40; i++) step(1'b1, W'(1), W'(1), 1'b0);
    idle(20);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, pick(), pick(), $urandom_range(0, 99) == 0);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 100) begin
      idle(1);
      wait_cnt++;
    end
    idle(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d operations still outstanding, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
